instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the instruction word driven on instr when no valid fetch data exists.
REQ-002 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 pc  in  32  current fetch address from the program counter.
REQ-005 pc_en  out  1  program-counter load enable; one-cycle pulse, combinational.
REQ-006 flush  in  1  branch/jump redirect pulse; the program counter loads its target on the same edge.
REQ-007 mem_req  out  1  instruction-bus request, registered.
REQ-008 mem_addr  out  32  instruction-bus word address, registered; bits [1:0] always 0.
REQ-009 mem_gnt  in  1  bus accepts the request in the cycle mem_req && mem_gnt.
REQ-010 mem_rvalid  in  1  response valid; at most one response per granted request, no earlier than the cycle after grant.
REQ-011 mem_rdata  in  32  response data, sampled when mem_rvalid=1.
REQ-012 mem_err  in  1  response error, sampled when mem_rvalid=1.
REQ-013 instr  out  32  fetched instruction, registered.
REQ-014 instr_pc  out  32  address of instr, registered.
REQ-015 instr_valid  out  1  instr/instr_pc/fetch_fault valid, registered.
REQ-016 instr_ready  in  1  decode accepts the word in the cycle instr_valid && instr_ready.
REQ-017 fetch_fault  out  1  qualifies instr_valid as a fault: misaligned pc or bus error.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, HOLD and DROP.
REQ-019 IDLE: mem_req=0; the next state SHALL be REQ, with mem_addr <= {pc[31:2],2'b00} and instr_pc <= pc latched on that edge.
REQ-020 Misaligned pc (pc[1:0]!=0) at the IDLE or HOLD->REQ latch edge: the unit SHALL go to HOLD instead of REQ, with instr_valid=1, fetch_fault=1, instr=NOP_INSTR and instr_pc=pc; no bus request SHALL be issued.
REQ-021 REQ: mem_req=1, and mem_addr SHALL stay stable until grant; on mem_gnt the next state SHALL be WAIT and mem_req SHALL deassert.
REQ-022 WAIT, mem_rvalid && !mem_err: instr <= mem_rdata, instr_valid <= 1, fetch_fault <= 0, pc_en=1 for that cycle, next state HOLD.
REQ-023 WAIT, mem_rvalid && mem_err: instr <= NOP_INSTR, instr_valid <= 1, fetch_fault <= 1, pc_en=0, next state HOLD.
REQ-024 HOLD: outputs SHALL be held; on instr_valid && instr_ready, instr_valid <= 0 and the next state SHALL be REQ, latching the new pc as in REQ-019, with the misalignment check of REQ-020 applied.
REQ-025 A fault word (fetch_fault=1) SHALL never assert pc_en; after the fault is consumed, the unit SHALL refetch from the current pc.
REQ-026 Fetch latency, grant in the same cycle as mem_req and rvalid one cycle after grant: instr_valid SHALL rise 2 cycles after REQ entry.
REQ-027 Throughput with no stalls: one instruction per 3 cycles.
REQ-028 Flush in any state: pc_en=1 in that cycle; instr_valid <= 0; fetch_fault <= 0; any mem_rvalid in the same cycle SHALL be discarded.
REQ-029 Flush next state:
- IDLE/HOLD -> IDLE.
- WAIT without rvalid -> DROP.
- WAIT with rvalid -> IDLE.
- REQ with mem_gnt -> DROP.
- REQ without mem_gnt -> REQ, with mem_req held and the address unchanged; the later grant SHALL go to DROP.
- DROP -> DROP.
REQ-030 DROP: mem_req=0; the next mem_rvalid SHALL be discarded and the next state SHALL be IDLE.
REQ-031 Flush && instr_ready in the same cycle: flush SHALL win, and the consumed word SHALL not trigger a new request.
REQ-032 pc_en SHALL be 0 in every case not listed in REQ-022 and REQ-028.
REQ-033 mem_rvalid in IDLE, REQ or HOLD is a protocol violation; it SHALL be ignored.

Reset
REQ-034 While rst_n=0: state=IDLE, mem_req=0, mem_addr=0, instr=NOP_INSTR, instr_pc=0, instr_valid=0, fetch_fault=0, pc_en=0.
REQ-035 Reset deassertion mid-transaction SHALL leave no pending-response memory; the first request SHALL leave IDLE on the second edge after rst_n rises.

Verification
REQ-036 Reset, then pc=0, gnt immediate, rvalid next cycle with rdata=32'h00500093, instr_ready=1 -> mem_addr=0, instr=32'h00500093, instr_pc=0, one pc_en pulse; next request uses mem_addr=4.
REQ-037 instr_ready=0 for 5 cycles -> instr/instr_valid stable, mem_req=0, no pc_en; the next request issues the cycle after ready.
REQ-038 Flush while in WAIT, rvalid 3 cycles later with rdata=32'hDEADBEEF, pc target=32'h100 -> DEADBEEF never valid; the next mem_addr=32'h100.
REQ-039 pc=32'h102 at the latch edge -> no mem_req; instr_valid=1, fetch_fault=1, instr=32'h00000013, pc_en never asserted.
REQ-040 mem_err=1 on the response for pc=32'h40 -> fetch_fault=1, instr_pc=32'h40; after consumption mem_addr=32'h40 again.
REQ-041 gnt withheld for 4 cycles, then rst_n pulsed low -> mem_req=0 immediately, all outputs at reset values; after release the fetch restarts at pc.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one bus read per instruction, holds the word until
// decode accepts it, and discards in-flight responses after a redirect (flush).
module instr_fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic        pc_en,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_e;

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic        drop_pend_q, drop_pend_d;
    logic        started_q, started_d;
    logic        take_pc;

    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_fault_d = fetch_fault_q;
        drop_pend_d   = drop_pend_q;
        started_d     = 1'b1;
        pc_en         = 1'b0;
        take_pc       = 1'b0;

        case (state_q)
            IDLE: begin
                // started_q delays the first latch by one edge after reset release
                if (!flush && started_q) take_pc = 1'b1;
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d     = (flush || drop_pend_q) ? DROP : WAIT;
                    drop_pend_d = 1'b0;
                end else if (flush) begin
                    drop_pend_d = 1'b1;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = mem_rvalid ? IDLE : DROP;
                end else if (mem_rvalid) begin
                    instr_d       = mem_err ? NOP_INSTR : mem_rdata;
                    instr_valid_d = 1'b1;
                    fetch_fault_d = mem_err;
                    pc_en         = !mem_err;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (!flush && instr_valid_q && instr_ready) begin
                    take_pc       = 1'b1;
                    instr_valid_d = 1'b0;
                    fetch_fault_d = 1'b0;
                end
            end
            DROP: begin
                // the stale response is swallowed even if another flush arrives with it
                if (mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (take_pc) begin
            instr_pc_d = pc;
            if (pc[1:0] != 2'b00) begin
                state_d       = HOLD;
                instr_valid_d = 1'b1;
                fetch_fault_d = 1'b1;
                instr_d       = NOP_INSTR;
            end else begin
                state_d    = REQ;
                mem_addr_d = {pc[31:2], 2'b00};
            end
        end

        if (flush) begin
            pc_en         = 1'b1;
            instr_valid_d = 1'b0;
            fetch_fault_d = 1'b0;
            if (state_q == HOLD) state_d = IDLE;
        end

        mem_req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            drop_pend_q   <= 1'b0;
            started_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
            drop_pend_q   <= drop_pend_d;
            started_q     <= started_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_fault = fetch_fault_q;

endmodule
